// File: rtl/multiply_add.sv
// Sequential shift-add multiplier computing product = A*B + C over WIDTH-bit
// unsigned operands, one ADD/SHIFT pair per multiplier bit, then a final accumulate.
module multiply_add #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        ACCUM = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [WIDTH-1:0]     a_r, a_s;
    logic [WIDTH-1:0]     c_r, c_s;
    logic [WIDTH:0]       hi_r, hi_s;
    logic [WIDTH-1:0]     lo_r, lo_s;
    logic [CW-1:0]        count_r, count_s;
    logic [2*WIDTH-1:0]   product_r, product_s;
    logic                 done_r, done_s;

    // Next-state and datapath update; every register holds unless its state acts on it.
    always_comb begin
        state_s   = state_r;
        a_s       = a_r;
        c_s       = c_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        count_s   = count_r;
        product_s = product_r;
        done_s    = done_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = multiplicand;
                    c_s     = addend;
                    hi_s    = '0;
                    lo_s    = multiplier;
                    count_s = CW'(WIDTH);
                    done_s  = 1'b0;
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                // hi[WIDTH] is always clear here, so the low bits carry the whole partial sum
                if (lo_r[0]) begin
                    hi_s = {1'b0, hi_r[WIDTH-1:0]} + {1'b0, a_r};
                end else begin
                    hi_s = hi_r;
                end
                state_s = SHIFT;
            end
            SHIFT: begin
                hi_s    = {1'b0, hi_r[WIDTH:1]};
                lo_s    = {hi_r[0], lo_r[WIDTH-1:1]};
                count_s = count_r - CW'(1);
                if (count_r > CW'(1)) begin
                    state_s = ADD;
                end else begin
                    state_s = ACCUM;
                end
            end
            ACCUM: begin
                product_s = {hi_r[WIDTH-1:0], lo_r} + {{WIDTH{1'b0}}, c_r};
                done_s    = 1'b1;
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset clears everything and aborts any operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r       <= '0;
            c_r       <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            count_r   <= '0;
            product_r <= '0;
            done_r    <= 1'b1;
        end else begin
            a_r       <= a_s;
            c_r       <= c_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            count_r   <= count_s;
            product_r <= product_s;
            done_r    <= done_s;
        end
    end

    assign product = product_r;
    assign done    = done_r;

endmodule

// File: tb/tb_multiply_add.sv
// Scoreboard bench for multiply_add: the driver queues expected results, a monitor
// pops and checks them (value and latency) on every rising edge of done.
module tb_multiply_add;

    localparam int W       = 8;
    localparam int LATENCY = 2 * W + 1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier   = '0;
    logic [W-1:0]   addend       = '0;
    logic [2*W-1:0] product;
    logic           done;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    typedef struct {
        int value;
        int start_cycle;
    } exp_t;
    exp_t sb_q[$];

    multiply_add #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .done         (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog expired");
    end

    function automatic int ref_mad(input int a, input int b, input int c);
        return a * b + c;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: product must hold while busy; each done rise consumes one expectation.
    initial begin
        bit           prev_done = 1'b1;
        logic [15:0]  last_p    = '0;
        exp_t         e;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                prev_done = done;
                last_p    = product;
            end else begin
                if (!done) check("product_hold", product, last_p);
                if (done && !prev_done) begin
                    if (sb_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL spurious_done: done rose with product %0d and nothing expected", product);
                    end else begin
                        e = sb_q.pop_front();
                        check("product", product, e.value);
                        check("latency", cycle - e.start_cycle, LATENCY);
                    end
                    last_p = product;
                end
                prev_done = done;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input int exp_value, input bit track);
        exp_t e;
        @(negedge clock);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        @(posedge clock);
        #1;
        if (track) begin
            e.value       = exp_value;
            e.start_cycle = cycle;
            sb_q.push_back(e);
        end
        check("done_low", done, 1'b0);
        @(negedge clock);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        addend       = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 3 * LATENCY) begin
            @(posedge clock);
            #1;
            n++;
            if (done) break;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        run_op(a, b, c, ref_mad(int'(a), int'(b), int'(c)), 1'b1);
        wait_done();
    endtask

    initial begin
        exp_t e;
        int   n, d;
        logic [W-1:0] qa, qb, qc;

        reset = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("reset_done", done, 1'b1);
        check("reset_product", product, 16'd0);
        repeat (20) @(posedge clock);
        #1;
        check("idle_done", done, 1'b1);
        check("idle_product", product, 16'd0);

        // Directed values with known answers.
        run_op(8'd31, 8'd113, 8'd47, 3550, 1'b1);  wait_done();
        run_op(8'd31, 8'd112, 8'd78, 3550, 1'b1);  wait_done();
        run_op(8'd6, 8'd15, 8'd10, 100, 1'b1);     wait_done();
        run_op(8'd255, 8'd255, 8'd255, 65280, 1'b1); wait_done();
        run_op(8'd0, 8'd200, 8'd0, 0, 1'b1);       wait_done();
        op(8'd200, 8'd0, 8'd9);

        // A start pulse mid-operation with new operands must be ignored.
        run_op(8'd12, 8'd5, 8'd3, 63, 1'b1);
        repeat (4) @(negedge clock);
        multiplicand = 8'd1;
        multiplier   = 8'd1;
        addend       = 8'd1;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (25) @(posedge clock);
        #1;
        check("no_second_op", done, 1'b1);
        check("no_second_product", product, 16'd63);

        // Reset mid-operation aborts it with no partial result.
        run_op(8'd100, 8'd100, 8'd0, 0, 1'b0);
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_done", done, 1'b1);
        check("abort_product", product, 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        op(8'd7, 8'd9, 8'd2);
        check("after_abort_product", product, 16'd65);

        // start held high: back-to-back operations with a one-cycle done gap.
        @(negedge clock);
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        addend       = W'($urandom);
        start        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            e.value       = ref_mad(int'(multiplicand), int'(multiplier), int'(addend));
            e.start_cycle = cycle;
            sb_q.push_back(e);
            check("held_done_low", done, 1'b0);
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            addend       = W'($urandom);
            if (k < 2) begin
                repeat (LATENCY) @(posedge clock);
                #1;
                check("held_done_gap", done, 1'b1);
            end
        end
        @(negedge clock);
        start = 1'b0;
        wait_done();

        // Loop-back against division: quotient*denominator + remainder == numerator.
        for (int i = 0; i < 1000; i++) begin
            d  = int'($urandom_range(1, 255));
            n  = int'($urandom_range(0, 256 * d - 1));
            qa = W'(n / d);
            qb = W'(d);
            qc = W'(n % d);
            run_op(qa, qb, qc, n, 1'b1);
            wait_done();
        end

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
